// File: rtl/cypher_pkg.sv
// Shared definitions for the cypher sender/detector link: FSM states, widths and
// the nibble-index-to-bit-slice convention used by both ends.
package cypher_pkg;
  localparam int NIBBLES  = 4;
  localparam int SUM_W    = 10;
  localparam int CNT_W    = 3;
  localparam int NIB_W    = 4;
  localparam int CYPHER_W = NIBBLES * NIB_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_e;

  // Index 0 is the most-significant nibble; out-of-range indices yield 0.
  function automatic logic [NIB_W-1:0] nib_slice(input logic [CYPHER_W-1:0] c,
                                                 input logic [CNT_W-1:0]    idx);
    logic [NIB_W-1:0] r;
    r = '0;
    for (int i = 0; i < NIBBLES; i++)
      if (idx == CNT_W'(i)) r = c[CYPHER_W-1-NIB_W*i -: NIB_W];
    return r;
  endfunction
endpackage

// File: rtl/cypher_sender_if.sv
// Source/sink side signals of the cypher sender; master is the sender itself.
interface cypher_sender_if;
  import cypher_pkg::*;

  logic                start;
  logic                abort;
  logic [CYPHER_W-1:0] fullcypher;
  logic                ready;
  logic [NIB_W-1:0]    seq_output;
  logic                valid;
  logic                busy;
  logic                done;
  logic [SUM_W-1:0]    sum;

  modport master (
    input  start, abort, fullcypher, ready,
    output seq_output, valid, busy, done, sum
  );

  modport slave (
    output start, abort, fullcypher, ready,
    input  seq_output, valid, busy, done, sum
  );
endinterface

// File: rtl/cypher_nibble_sel.sv
// Combinational 16->4 symbol mux indexed by the nibble counter.
module cypher_nibble_sel
  import cypher_pkg::*;
(
  input  logic [CYPHER_W-1:0] cypher_i,
  input  logic [CNT_W-1:0]    idx_i,
  output logic [NIB_W-1:0]    nib_o
);
  assign nib_o = nib_slice(cypher_i, idx_i);
endmodule

// File: rtl/cypher_sender.sv
// Latches a 16-bit cypher on start and streams it MS-nibble first over
// valid/ready, keeping a running sum of accepted symbols.
module cypher_sender
  import cypher_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  cypher_sender_if.master  bus
);
  state_e              state_q, state_d;
  logic [CYPHER_W-1:0] cypher_q, cypher_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [SUM_W-1:0]    sum_q, sum_d;
  logic [NIB_W-1:0]    nib;
  logic                valid, busy, done;
  logic [NIB_W-1:0]    seq;

  cypher_nibble_sel u_sel (
    .cypher_i (cypher_q),
    .idx_i    (cnt_q),
    .nib_o    (nib)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      cypher_q <= '0;
      cnt_q    <= '0;
      sum_q    <= '0;
    end else begin
      state_q  <= state_d;
      cypher_q <= cypher_d;
      cnt_q    <= cnt_d;
      sum_q    <= sum_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cypher_d = cypher_q;
    cnt_d    = cnt_q;
    sum_d    = sum_q;
    valid    = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    seq      = '0;
    case (state_q)
      IDLE: begin
        // start wins over a simultaneous abort here
        if (bus.start) begin
          state_d  = SEND;
          cypher_d = bus.fullcypher;
          cnt_d    = '0;
          sum_d    = '0;
        end
      end
      SEND: begin
        valid = 1'b1;
        busy  = 1'b1;
        seq   = nib;
        // abort beats an accept in the same cycle: the symbol is not counted
        if (bus.abort) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (bus.ready) begin
          sum_d = sum_q + SUM_W'(nib);
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(NIBBLES - 1)) state_d = DONE;
        end
      end
      DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = IDLE;
        if (bus.abort) cnt_d = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.valid      = valid;
  assign bus.busy       = busy;
  assign bus.done       = done;
  assign bus.seq_output = seq;
  assign bus.sum        = sum_q;
endmodule
